// File: rtl/mult_sched_pkg.sv
// Shared state encoding and default widths for the multiplier job sequencer.
package mult_sched_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    typedef enum logic [3:0] {
        IDLE,
        RD_A,
        CAP_A,
        RD_B,
        CAP_B,
        START,
        WAIT,
        WR_LO,
        WR_HI
    } sched_state_t;

endpackage

// File: rtl/mult_fifo_scheduler.sv
// Sequences one multiplication at a time: pop A then B from the operand FIFO,
// start the multiplier, wait for done, and push the product low word first.
module mult_fifo_scheduler
    import mult_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    in_empty,
    output logic                    in_r_en,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    mul_start,
    output logic [DATA_WIDTH-1:0]   mul_a,
    output logic [DATA_WIDTH-1:0]   mul_b,
    input  logic                    mul_done,
    input  logic [2*DATA_WIDTH-1:0] mul_result,
    input  logic                    out_full,
    output logic                    out_w_en,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    job_count
);

    sched_state_t            state;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [2*DATA_WIDTH-1:0] result;

    // NOTE: every register here is written with <= so all state updates see
    // the pre-edge values, regardless of statement order in the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            job_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= RD_A;
                end
                RD_A: begin
                    if (!in_empty) state <= CAP_A;
                end
                CAP_A: begin
                    a_reg <= in_data;
                    state <= RD_B;
                end
                RD_B: begin
                    if (!in_empty) state <= CAP_B;
                end
                CAP_B: begin
                    b_reg <= in_data;
                    state <= START;
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        result <= mul_result;
                        state  <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (!out_full) state <= WR_HI;
                end
                WR_HI: begin
                    if (!out_full) begin
                        job_count <= job_count + 1'b1;
                        state     <= enable ? RD_A : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes follow the FIFO flags in the same cycle, so a stall never
    // costs an extra cycle once the flag clears.
    assign in_r_en   = ((state == RD_A) || (state == RD_B)) && !in_empty;
    assign out_w_en  = ((state == WR_LO) || (state == WR_HI)) && !out_full;
    assign mul_start = (state == START);
    assign busy      = (state != IDLE);

    assign mul_a    = a_reg;
    assign mul_b    = b_reg;
    assign out_data = (state == WR_HI) ? result[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : result[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_mult_fifo_scheduler.sv
// Scoreboard bench for mult_fifo_scheduler with behavioural FIFO and multiplier models.
`timescale 1ns/1ps
module tb_mult_fifo_scheduler;

    localparam int DW = 8;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          is_hi;
        logic [CW-1:0] cnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            in_empty = 1'b1;
    logic            in_r_en;
    logic [DW-1:0]   in_data = '0;
    logic            mul_start;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic            mul_done = 1'b0;
    logic [2*DW-1:0] mul_result = '0;
    logic            out_full = 1'b0;
    logic            out_w_en;
    logic [DW-1:0]   out_data;
    logic            busy;
    logic [CW-1:0]   job_count;

    logic [DW-1:0]   in_q[$];
    exp_t            exp_q[$];
    exp_t            mon_e;
    logic            mon_cnt_pending = 1'b0;
    logic [CW-1:0]   mon_cnt_exp = '0;
    logic            env_rd = 1'b0;
    logic [2*DW-1:0] mul_prod = '0;
    logic            hold_empty = 1'b0;
    int              mul_lat = 3;
    int              mul_cnt = 0;
    int              exp_jobs = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              lo_cyc = 0;
    int              hi_cyc = 0;

    mult_fifo_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_empty   (in_empty),
        .in_r_en    (in_r_en),
        .in_data    (in_data),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_full   (out_full),
        .out_w_en   (out_w_en),
        .out_data   (out_data),
        .busy       (busy),
        .job_count  (job_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Operand FIFO with registered read data, and a fixed-latency multiplier.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                env_rd   = 1'b0;
                mul_cnt  = 0;
                mul_done = 1'b0;
            end else begin
                if (env_rd && in_q.size() > 0) in_data = in_q.pop_front();
                mul_done = 1'b0;
                if (mul_cnt > 0) begin
                    mul_cnt--;
                    if (mul_cnt == 0) begin
                        mul_done   = 1'b1;
                        mul_result = mul_prod;
                    end
                end
            end
            #1;
            in_empty = hold_empty || (in_q.size() == 0);
            @(negedge clk);
            env_rd = in_r_en;
            if (mul_start) begin
                mul_prod = mul_a * mul_b;
                mul_cnt  = mul_lat;
            end
        end
    end

    // Monitor: every accepted output write is popped against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_cnt_pending = 1'b0;
            end else begin
                if (mon_cnt_pending) begin
                    check("job_count", job_count, mon_cnt_exp);
                    mon_cnt_pending = 1'b0;
                end
                if (out_w_en) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got 0x%0h, expected no write", out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.is_hi) begin
                            check("out_data_hi", out_data, mon_e.data);
                            hi_cyc          = cyc;
                            mon_cnt_pending = 1'b1;
                            mon_cnt_exp     = mon_e.cnt;
                        end else begin
                            check("out_data_lo", out_data, mon_e.data);
                            lo_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_in(input logic [DW-1:0] w);
        in_q.push_back(w);
    endtask

    task automatic push_exp(input logic [2*DW-1:0] prod);
        exp_t e;
        exp_jobs++;
        e.data  = prod[DW-1:0];
        e.is_hi = 1'b0;
        e.cnt   = CW'(exp_jobs);
        exp_q.push_back(e);
        e.data  = prod[2*DW-1:DW];
        e.is_hi = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic queue_job(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [2*DW-1:0] prod);
        push_in(a);
        push_in(b);
        push_exp(prod);
    endtask

    task automatic wait_drain(input string name, input int max);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max) begin
            tick(1);
            k++;
        end
        check({name, "_drained"}, exp_q.size() == 0, 1);
    endtask

    task automatic wait_start(input string name, input int max);
        int k;
        k = 0;
        while (!mul_start && k < max) begin
            tick(1);
            k++;
        end
        check({name, "_mul_start"}, mul_start, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_r_en"}, in_r_en, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_out_w_en"}, out_w_en, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_job_count"}, job_count, 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next edge.
    task automatic reset_and_check(input string tag);
        #1;
        rst = 1'b1;
        in_q.delete();
        exp_q.delete();
        mul_cnt    = 0;
        mul_done   = 1'b0;
        exp_jobs   = 0;
        hold_empty = 1'b0;
        out_full   = 1'b0;
        enable     = 1'b0;
        in_empty   = 1'b1;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int k;
        int stall_reads;
        int rd_cyc;

        #3;
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // Single job from idle: 0x0F * 0x11 = 0x00FF, latency 3 -> 10 cycles from RD_A.
        mul_lat = 3;
        queue_job(8'h0F, 8'h11, 16'h00FF);
        enable = 1'b1;
        k = 0;
        while (!in_r_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("single_rd_a", in_r_en, 1);
        rd_cyc = cyc;
        tick(1);
        wait_drain("single", 50);
        tick(1);
        check("single_job_cycles", hi_cyc - rd_cyc + 1, 10);

        // Input empty between A and B: no reads while empty, operands keep their order.
        push_in(8'h0F);
        push_exp(16'h00FF);
        tick(2);
        stall_reads = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_r_en) stall_reads++;
        end
        check("empty_stall_reads", stall_reads, 0);
        check("empty_stall_busy", busy, 1);
        @(posedge clk);
        #1;
        push_in(8'h11);
        wait_start("empty", 20);
        check("empty_mul_a", mul_a, 8'h0F);
        check("empty_mul_b", mul_b, 8'h11);
        wait_drain("empty", 50);

        // Output full for 4 cycles in WR_LO: 0xFF * 0xFF = 0xFE01.
        out_full = 1'b1;
        mul_lat  = 2;
        queue_job(8'hFF, 8'hFF, 16'hFE01);
        k = 0;
        while (!mul_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("full_mul_done_seen", mul_done, 1);
        stall_reads = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_w_en) stall_reads++;
        end
        check("full_no_write", stall_reads, 0);
        @(posedge clk);
        #1;
        out_full = 1'b0;
        wait_drain("full", 20);
        tick(1);
        check("full_consecutive", hi_cyc - lo_cyc, 1);

        // Reset while the multiplier is still running.
        mul_lat = 20;
        queue_job(8'h0A, 8'h0B, 16'h006E);
        wait_start("rst", 30);
        tick(3);
        check("rst_busy_before", busy, 1);
        check("rst_mul_a_before", mul_a, 8'h0A);
        reset_and_check("rst_mid_wait");

        // Enable dropped during the first WAIT: one job completes, four words remain.
        mul_lat = 4;
        queue_job(8'h03, 8'h05, 16'h000F);
        push_in(8'h02);
        push_in(8'h02);
        push_in(8'h07);
        push_in(8'h07);
        enable = 1'b1;
        wait_start("endrop", 30);
        tick(1);
        enable = 1'b0;
        wait_drain("endrop", 40);
        tick(3);
        check("endrop_idle", busy, 0);
        check("endrop_job_count", job_count, 1);
        check("endrop_in_left", in_q.size(), 4);

        // Counter wrap with a 2-bit counter: 1, 2, 3, 0, 1.
        reset_and_check("rst_wrap");
        mul_lat = 1;
        queue_job(8'h01, 8'h01, 16'h0001);
        queue_job(8'h02, 8'h03, 16'h0006);
        queue_job(8'h04, 8'h05, 16'h0014);
        queue_job(8'h10, 8'h10, 16'h0100);
        queue_job(8'hFF, 8'h02, 16'h01FE);
        enable = 1'b1;
        wait_drain("wrap", 200);
        tick(2);
        check("wrap_final_count", job_count, 1);
        check("wrap_in_empty", in_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
